// File: rtl/display_bitplane_source_if.sv
// Pixel-write and buffer-flip bus between a frame producer (master) and
// the bitplane source (slave).
interface display_bitplane_source_if #(
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitdepth = 8
);
  localparam int addr_w = $clog2(2 * rows * columns);

  logic                  wr_en;
  logic [addr_w-1:0]     wr_addr;
  logic [3*bitdepth-1:0] wr_data;
  logic                  flip_req;
  logic                  flip_pending;
  logic                  flip_done;

  modport master (
    output wr_en, wr_addr, wr_data, flip_req,
    input  flip_pending, flip_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, flip_req,
    output flip_pending, flip_done
  );
endinterface

// File: rtl/display_bitplane_source.sv
// Double-buffered RGB frame store for a split-scan LED panel: turns the driver's
// row/column/PWM-cycle scan into per-channel data bits, 2 clocks after the address.
//
// Flip FSM
//   state   | meaning
//   idle    | no swap requested
//   pending | swap accepted, waiting for safe_flip
module display_bitplane_source #(
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int bitdepth = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(rows)-1:0]     row,
  input  logic [$clog2(columns)-1:0]  column,
  input  logic [bitdepth-1:0]         cycle,
  input  logic                        safe_flip,
  display_bitplane_source_if.slave    pix,
  output logic [2:0]                  rgb_top,
  output logic [2:0]                  rgb_bot
);

  localparam int depth  = rows * columns;
  localparam int idx_w  = $clog2(depth);
  localparam int addr_w = $clog2(2 * depth);
  localparam int dw     = 3 * bitdepth;

  typedef enum logic {idle, pending} state_t;

  state_t           state;
  logic             front_sel;
  logic [dw-1:0]    mem_top [2][depth];
  logic [dw-1:0]    mem_bot [2][depth];
  logic [dw-1:0]    top_q, bot_q;
  logic [bitdepth-1:0] cyc_q;

  logic             wr_hit, wr_lower;
  logic [idx_w-1:0] wr_idx, rd_idx;

  function automatic logic [2:0] lit(input logic [dw-1:0] w, input logic [bitdepth-1:0] c);
    return {w[3*bitdepth-1 -: bitdepth] > c,
            w[2*bitdepth-1 -: bitdepth] > c,
            w[bitdepth-1:0] > c};
  endfunction

  always_comb begin
    wr_hit   = pix.wr_en && ({1'b0, pix.wr_addr} < (addr_w + 1)'(2 * depth));
    wr_lower = pix.wr_addr < addr_w'(depth);
    wr_idx   = idx_w'(pix.wr_addr - (wr_lower ? '0 : addr_w'(depth)));
    rd_idx   = idx_w'(32'(row) * columns + 32'(column));
  end

  // Storage is intentionally left out of reset; writes always target the back bank.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      if (wr_lower) mem_top[~front_sel][wr_idx] <= pix.wr_data;
      else          mem_bot[~front_sel][wr_idx] <= pix.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_q   <= '0;
      bot_q   <= '0;
      cyc_q   <= '0;
      rgb_top <= '0;
      rgb_bot <= '0;
    end else begin
      top_q   <= mem_top[front_sel][rd_idx];
      bot_q   <= mem_bot[front_sel][rd_idx];
      cyc_q   <= cycle;
      rgb_top <= lit(top_q, cyc_q);
      rgb_bot <= lit(bot_q, cyc_q);
    end
  end

  // A request arriving together with safe_flip swaps on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= idle;
      front_sel        <= 1'b0;
      pix.flip_pending <= 1'b0;
      pix.flip_done    <= 1'b0;
    end else begin
      pix.flip_done <= 1'b0;
      if (safe_flip && (state == pending || pix.flip_req)) begin
        state            <= idle;
        front_sel        <= ~front_sel;
        pix.flip_pending <= 1'b0;
        pix.flip_done    <= 1'b1;
      end else if (pix.flip_req) begin
        state            <= pending;
        pix.flip_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_bitplane_source.sv
// Randomised scoreboard bench for display_bitplane_source with directed
// scenarios for compare boundaries, flip gating, reset and out-of-range writes.
module tb_display_bitplane_source;
  localparam int ROWS = 8, COLS = 32, BD = 8;
  localparam int NPIX = 2 * ROWS * COLS;
  localparam int HALF = ROWS * COLS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] row = '0;
  logic [4:0] column = '0;
  logic [7:0] cycle = '0;
  logic       safe_flip = 1'b0;
  logic [2:0] rgb_top, rgb_bot;

  logic [2:0] row2 = '0;
  logic [4:0] col2 = '0;
  logic [7:0] cyc2 = '0;
  logic       sf2 = 1'b0;
  logic [2:0] rgb_top2, rgb_bot2;

  display_bitplane_source_if #(.rows(ROWS), .columns(COLS), .bitdepth(BD)) bus ();
  display_bitplane_source_if #(.rows(5), .columns(20), .bitdepth(BD)) bus2 ();

  display_bitplane_source #(.rows(ROWS), .columns(COLS), .bitdepth(BD)) dut (
    .clk(clk), .rst(rst_n), .row(row), .column(column), .cycle(cycle),
    .safe_flip(safe_flip), .pix(bus), .rgb_top(rgb_top), .rgb_bot(rgb_bot));

  display_bitplane_source #(.rows(5), .columns(20), .bitdepth(BD)) dut2 (
    .clk(clk), .rst(rst_n), .row(row2), .column(col2), .cycle(cyc2),
    .safe_flip(sf2), .pix(bus2), .rgb_top(rgb_top2), .rgb_bot(rgb_bot2));

  // Reference model: flat pixel buffers indexed y*COLS+x, one per bank.
  logic [23:0] pix_m [2][NPIX];
  bit          known [2][NPIX];
  bit          m_front = 1'b0;
  bit          m_pend  = 1'b0;

  typedef struct { bit chk; logic [2:0] top; logic [2:0] bot; } rgb_exp_t;
  typedef struct { bit done; bit pend; } flip_exp_t;
  rgb_exp_t  rq[$];
  flip_exp_t fq[$];

  int errors = 0;
  int checks = 0;

  function automatic logic [2:0] lit(input logic [23:0] w, input logic [7:0] c);
    logic [2:0] res;
    for (int ch = 0; ch < 3; ch++) begin
      logic [7:0] v;
      v = 8'(w >> (16 - 8 * ch));
      res[2-ch] = (v > c);
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    rgb_exp_t  e;
    flip_exp_t f;
    int ti, bi;
    ti = int'(row) * COLS + int'(column);
    bi = (int'(row) + ROWS) * COLS + int'(column);
    if (!rst_n) begin
      e.chk = 1'b1; e.top = '0; e.bot = '0;
      m_front = 1'b0; m_pend = 1'b0;
      f.done = 1'b0;
    end else begin
      e.chk = known[m_front][ti] && known[m_front][bi];
      e.top = lit(pix_m[m_front][ti], cycle);
      e.bot = lit(pix_m[m_front][bi], cycle);
      if (bus.wr_en && int'(bus.wr_addr) < NPIX) begin
        pix_m[!m_front][bus.wr_addr] = bus.wr_data;
        known[!m_front][bus.wr_addr] = 1'b1;
      end
      if ((m_pend || bus.flip_req) && safe_flip) begin
        m_front = !m_front; m_pend = 1'b0; f.done = 1'b1;
      end else begin
        f.done = 1'b0;
        if (bus.flip_req) m_pend = 1'b1;
      end
    end
    f.pend = m_pend;
    rq.push_back(e);
    fq.push_back(f);
  endtask

  task automatic step(input int r, input int c, input int cy, input int sf,
                      input int we, input int a, input int d, input int fr);
    row = 3'(r); column = 5'(c); cycle = 8'(cy); safe_flip = sf[0];
    bus.wr_en = we[0]; bus.wr_addr = 9'(a); bus.wr_data = 24'(d); bus.flip_req = fr[0];
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_step();
    step($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 255), 0, 0, 0, 0, 0);
  endtask

  task automatic step2(input int we, input int a, input int d, input int fr, input int sf,
                       input int cy);
    bus2.wr_en = we[0]; bus2.wr_addr = 8'(a); bus2.wr_data = 24'(d);
    bus2.flip_req = fr[0]; sf2 = sf[0]; cyc2 = 8'(cy);
    idle_step();
  endtask

  // Monitor: outputs after edge k reflect the read issued at edge k-1.
  initial begin
    rgb_exp_t  e;
    flip_exp_t f;
    forever begin
      @(posedge clk);
      #2;
      if (rq.size() >= 2) begin
        e = rq.pop_front();
        if (e.chk) begin
          chk("sb_rgb_top", 32'(rgb_top), 32'(e.top));
          chk("sb_rgb_bot", 32'(rgb_bot), 32'(e.bot));
        end
      end
      if (fq.size() >= 1) begin
        f = fq.pop_front();
        chk("sb_flip_done", 32'(bus.flip_done), 32'(f.done));
        chk("sb_flip_pending", 32'(bus.flip_pending), 32'(f.pend));
      end
    end
  end

  initial begin
    int pulses;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.flip_req = 1'b0;
    bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0; bus2.flip_req = 1'b0;

    for (int i = 0; i < 3; i++) idle_step();
    chk("reset_rgb_top", 32'(rgb_top), 0);
    chk("reset_rgb_bot", 32'(rgb_bot), 0);
    chk("reset_flip_pending", 32'(bus.flip_pending), 0);
    chk("reset_flip_done", 32'(bus.flip_done), 0);
    rst_n = 1'b1;

    // Fill both banks so every read has a defined expectation.
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < NPIX; a++)
        step($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 255), 0, 1, a,
             int'($urandom_range(0, 24'hFFFFFF)), 0);
      step(0, 0, 0, 1, 0, 0, 0, 1);
    end

    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 255),
           int'($urandom_range(0, 9) == 0), int'($urandom_range(0, 1)),
           $urandom_range(0, NPIX - 1), int'($urandom_range(0, 24'hFFFFFF)),
           int'($urandom_range(0, 49) == 0));
    if (m_pend) step(0, 0, 0, 1, 0, 0, 0, 0);

    // Top compare boundaries on a freshly flipped word.
    step(0, 0, 0, 0, 1, 0, 24'h8000FF, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 8'h7F, 0, 0, 0, 0, 0);
    step(0, 0, 8'h80, 0, 0, 0, 0, 0);
    chk("top_cycle_7f", 32'(rgb_top), 32'b101);
    step(0, 0, 8'hFF, 0, 0, 0, 0, 0);
    chk("top_cycle_80", 32'(rgb_top), 32'b001);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("top_cycle_ff", 32'(rgb_top), 32'b000);

    // Bottom half: pixel 261 is y=8, x=5, shown on row 0 column 5.
    step(0, 0, 0, 0, 1, 261, 24'h010101, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 5, 0, 0, 0, 0, 0, 0);
    step(0, 5, 1, 0, 0, 0, 0, 0);
    chk("bot_cycle_0", 32'(rgb_bot), 32'b111);
    step(0, 5, 0, 0, 0, 0, 0, 0);
    chk("bot_cycle_1", 32'(rgb_bot), 32'b000);

    // Flip gating: request held off for 100 cycles, then one swap.
    step(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 100; i++) idle_step();
    chk("gated_flip_pending", 32'(bus.flip_pending), 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 255), 1, 0, 0, 0, 0);
      if (bus.flip_done) pulses++;
    end
    chk("flip_done_pulses", 32'(pulses), 1);
    chk("flip_pending_after_swap", 32'(bus.flip_pending), 0);

    // Request, safe_flip and a write all on one edge.
    step(0, 0, 0, 1, 1, 0, 24'hFF0000, 1);
    step(0, 0, 8'h10, 0, 0, 0, 0, 0);
    step(0, 0, 8'h10, 0, 0, 0, 0, 0);
    chk("coincident_write_top", 32'(rgb_top), 32'b100);

    // Reset with a flip pending while bank 1 is in front.
    if (!m_front) step(0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("pre_reset_pending", 32'(bus.flip_pending), 1);
    rst_n = 1'b0;
    rq.delete(); fq.delete();
    m_front = 1'b0; m_pend = 1'b0;
    #1;
    chk("midreset_rgb_top", 32'(rgb_top), 0);
    chk("midreset_rgb_bot", 32'(rgb_bot), 0);
    chk("midreset_flip_pending", 32'(bus.flip_pending), 0);
    chk("midreset_flip_done", 32'(bus.flip_done), 0);
    idle_step(); idle_step();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) idle_step();

    // Out-of-range writes on a non-power-of-two panel (200 pixels, 8-bit address).
    step2(1, 0, 24'h505050, 0, 0, 0);
    step2(1, 100, 24'h404040, 0, 0, 0);
    for (int a = 200; a < 256; a++) step2(1, a, 24'hFFFFFF, 0, 0, 0);
    step2(0, 0, 0, 1, 1, 0);
    step2(0, 0, 0, 0, 0, 8'h3F);
    step2(0, 0, 0, 0, 0, 8'h40);
    chk("oor_top_3f", 32'(rgb_top2), 32'b111);
    chk("oor_bot_3f", 32'(rgb_bot2), 32'b111);
    step2(0, 0, 0, 0, 0, 8'h50);
    chk("oor_top_40", 32'(rgb_top2), 32'b111);
    chk("oor_bot_40", 32'(rgb_bot2), 32'b000);
    step2(0, 0, 0, 0, 0, 0);
    chk("oor_top_50", 32'(rgb_top2), 32'b000);

    idle_step(); idle_step(); idle_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end
endmodule
